// File: rtl/branch_resolve_pkg.sv
// Shared constants for the branch resolution slice: opcodes, funct3 encodings
// and the resolver FSM state type.
package branch_resolve_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/branch_resolve_decide.sv
// Combinational taken/target evaluation for the EX-stage instruction.
// Target arithmetic is modulo 2^DWIDTH; JALR clears bit 0 of its sum.
module branch_decide
  import branch_resolve_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  output logic              is_branch,
  output logic              taken,
  output logic              illegal,
  output logic [DWIDTH-1:0] target
);

  logic [DWIDTH-1:0] pc_sum;
  logic [DWIDTH-1:0] rs1_sum;

  assign pc_sum  = pc_i + imm_i;
  assign rs1_sum = rs1_i + imm_i;

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    illegal   = 1'b0;
    target    = pc_sum;
    case (opcode_i)
      OP_BRANCH: begin
        is_branch = 1'b1;
        case (funct3_i)
          F3_BEQ:           taken = breq_i;
          F3_BNE:           taken = !breq_i;
          F3_BLT, F3_BLTU:  taken = brlt_i;
          F3_BGE, F3_BGEU:  taken = !brlt_i;
          F3_RSV2, F3_RSV3: illegal = 1'b1;
          default:          taken = 1'b0;
        endcase
      end
      OP_JAL: taken = 1'b1;
      OP_JALR: begin
        taken  = 1'b1;
        target = {rs1_sum[DWIDTH-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolver: samples the instruction in IDLE, issues a redirect
// to fetch, then squashes younger instructions for FLUSH_CYCLES cycles.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  input  logic              redirect_ready_i,
  output logic              redirect_valid_o,
  output logic [DWIDTH-1:0] redirect_pc_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic              misalign_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  taken_cnt_o,
  output state_e            state_o
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e            state, state_next;
  logic [2:0]        flush_cnt, flush_cnt_next;
  logic              sample;
  logic              dec_is_branch, dec_taken, dec_illegal;
  logic [DWIDTH-1:0] dec_target;

  branch_decide #(.DWIDTH(DWIDTH)) u_decide (
    .opcode_i  (opcode_i),
    .funct3_i  (funct3_i),
    .pc_i      (pc_i),
    .imm_i     (imm_i),
    .rs1_i     (rs1_i),
    .breq_i    (breq_i),
    .brlt_i    (brlt_i),
    .is_branch (dec_is_branch),
    .taken     (dec_taken),
    .illegal   (dec_illegal),
    .target    (dec_target)
  );

  // Decision inputs are only looked at when nothing is in flight.
  assign sample = ex_valid_i && (state == ST_IDLE);

  // Handshake: redirect_valid_o rises one cycle after a taken sample and stays
  // high with redirect_pc_o frozen; the transfer happens in the first cycle
  // where redirect_ready_i is also high.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      ST_IDLE: begin
        if (sample && dec_taken) state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready_i) begin
          if (FLUSH_CYCLES == 0) begin
            state_next = ST_IDLE;
          end else begin
            state_next     = ST_FLUSH;
            flush_cnt_next = FLUSH_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt <= 3'd1) begin
          state_next     = ST_IDLE;
          flush_cnt_next = 3'd0;
        end else begin
          flush_cnt_next = flush_cnt - 3'd1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        flush_cnt_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      flush_cnt     <= 3'd0;
      redirect_pc_o <= '0;
      misalign_o    <= 1'b0;
      illegal_o     <= 1'b0;
      branch_cnt_o  <= '0;
      taken_cnt_o   <= '0;
    end else begin
      state      <= state_next;
      flush_cnt  <= flush_cnt_next;
      misalign_o <= sample && dec_taken && dec_target[1];
      illegal_o  <= sample && dec_illegal;
      if (sample && dec_taken) redirect_pc_o <= dec_target;
      if (sample && dec_is_branch && (branch_cnt_o != '1))
        branch_cnt_o <= branch_cnt_o + 1'b1;
      if (sample && dec_taken && (taken_cnt_o != '1))
        taken_cnt_o <= taken_cnt_o + 1'b1;
    end
  end

  assign redirect_valid_o = (state == ST_REDIRECT);
  assign flush_o          = (state == ST_FLUSH);
  assign busy_o           = (state != ST_IDLE);
  assign state_o          = state;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed plus randomized bench for branch_resolve; a second instance is
// built with FLUSH_CYCLES=0 to cover the direct return to IDLE.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_valid_z;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc, imm, rs1;
  logic        breq, brlt, ready;

  logic        redirect_valid, flush, busy, misalign, illegal;
  logic [31:0] redirect_pc, branch_cnt, taken_cnt;
  state_e      state;

  logic        z_redirect_valid, z_flush, z_busy, z_misalign, z_illegal;
  logic [31:0] z_redirect_pc, z_branch_cnt, z_taken_cnt;
  state_e      z_state;

  int checks = 0;
  int errors = 0;
  int exp_branch = 0;
  int exp_taken = 0;
  bit z_flush_seen = 1'b0;

  always #5 clk = ~clk;

  branch_resolve #(.DWIDTH(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .ex_valid_i(ex_valid), .opcode_i(opcode),
    .funct3_i(funct3), .pc_i(pc), .imm_i(imm), .rs1_i(rs1), .breq_i(breq),
    .brlt_i(brlt), .redirect_ready_i(ready), .redirect_valid_o(redirect_valid),
    .redirect_pc_o(redirect_pc), .flush_o(flush), .busy_o(busy),
    .misalign_o(misalign), .illegal_o(illegal), .branch_cnt_o(branch_cnt),
    .taken_cnt_o(taken_cnt), .state_o(state)
  );

  branch_resolve #(.DWIDTH(32), .FLUSH_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .ex_valid_i(ex_valid_z), .opcode_i(opcode),
    .funct3_i(funct3), .pc_i(pc), .imm_i(imm), .rs1_i(rs1), .breq_i(breq),
    .brlt_i(brlt), .redirect_ready_i(ready), .redirect_valid_o(z_redirect_valid),
    .redirect_pc_o(z_redirect_pc), .flush_o(z_flush), .busy_o(z_busy),
    .misalign_o(z_misalign), .illegal_o(z_illegal), .branch_cnt_o(z_branch_cnt),
    .taken_cnt_o(z_taken_cnt), .state_o(z_state)
  );

  always @(posedge clk) if (z_flush) z_flush_seen = 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference rules: what the instruction means, not how the RTL builds it.
  function automatic void ref_decide(
    input  logic [6:0] op, input logic [2:0] f3,
    input  logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
    input  logic eq, input logic lt,
    output bit is_b, output bit tk, output bit ill, output logic [31:0] tgt);
    longint unsigned sum;
    is_b = 0; tk = 0; ill = 0;
    sum  = (longint'(p) + longint'(im)) % 64'h1_0000_0000;
    tgt  = 32'(sum);
    if (op == 7'b1100011) begin
      is_b = 1;
      if (f3 == 3'd0) tk = eq;
      else if (f3 == 3'd1) tk = !eq;
      else if (f3 == 3'd4 || f3 == 3'd6) tk = lt;
      else if (f3 == 3'd5 || f3 == 3'd7) tk = !lt;
      else ill = 1;
    end else if (op == 7'b1101111) begin
      tk = 1;
    end else if (op == 7'b1100111) begin
      tk  = 1;
      sum = (longint'(r1) + longint'(im)) % 64'h1_0000_0000;
      tgt = 32'(sum) - 32'(sum % 2);
    end
  endfunction

  task automatic run_instr(
    input logic [6:0] op, input logic [2:0] f3, input logic [31:0] p,
    input logic [31:0] im, input logic [31:0] r1, input logic eq,
    input logic lt, input int delay);
    bit is_b, tk, ill;
    logic [31:0] tgt;
    ref_decide(op, f3, p, im, r1, eq, lt, is_b, tk, ill, tgt);
    opcode = op; funct3 = f3; pc = p; imm = im; rs1 = r1; breq = eq; brlt = lt;
    ex_valid = 1'b1; ready = 1'b0;
    tick();
    ex_valid = 1'b0;
    if (is_b) exp_branch++;
    if (tk) exp_taken++;
    check("redirect_valid", 32'(redirect_valid), 32'(tk));
    check("busy", 32'(busy), 32'(tk));
    check("misalign", 32'(misalign), 32'(tk && tgt[1]));
    check("illegal", 32'(illegal), 32'(ill));
    check("branch_cnt", branch_cnt, 32'(exp_branch));
    check("taken_cnt", taken_cnt, 32'(exp_taken));
    if (tk) begin
      check("redirect_pc", redirect_pc, tgt);
      for (int i = 0; i < delay; i++) begin
        ex_valid = 1'($urandom_range(0, 1));
        opcode = 7'b1101111; pc = $urandom; imm = $urandom;
        tick();
        check("hold_valid", 32'(redirect_valid), 32'd1);
        check("hold_pc", redirect_pc, tgt);
        check("pulse_end", 32'({misalign, illegal}), 32'd0);
      end
      ex_valid = 1'b0;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      for (int i = 0; i < FC; i++) begin
        check("flush", 32'(flush), 32'd1);
        check("flush_no_valid", 32'(redirect_valid), 32'd0);
        check("flush_pulses", 32'({misalign, illegal}), 32'd0);
        ex_valid = 1'($urandom_range(0, 1));
        opcode = 7'b1101111;
        tick();
      end
      ex_valid = 1'b0;
      check("idle_after_flush", 32'({flush, busy, redirect_valid}), 32'd0);
      check("cnt_ignored_b", branch_cnt, 32'(exp_branch));
      check("cnt_ignored_t", taken_cnt, 32'(exp_taken));
    end else begin
      tick();
      check("nt_idle", 32'({busy, redirect_valid, misalign, illegal}), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_valid_z = 1'b0; ready = 1'b0;
    opcode = '0; funct3 = '0; pc = '0; imm = '0; rs1 = '0; breq = 0; brlt = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_outs", 32'({redirect_valid, flush, busy, misalign, illegal}), 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_cnts", branch_cnt | taken_cnt, 32'd0);
    reset = 1'b0;
    tick();

    // BEQ taken, fetch stalls 3 cycles
    run_instr(OP_BRANCH, F3_BEQ, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 3);
    check("beq_target", redirect_pc, 32'h120);
    // BGE with brlt=1 is not taken
    run_instr(OP_BRANCH, F3_BGE, 32'h200, 32'h40, 32'h0, 1'b0, 1'b1, 0);
    // JALR to a target with bit 1 set
    run_instr(OP_JALR, 3'd0, 32'h400, 32'h0, 32'h203, 1'b0, 1'b0, 1);
    check("jalr_target", redirect_pc, 32'h202);
    // Reserved B-type funct3
    run_instr(OP_BRANCH, F3_RSV2, 32'h500, 32'h8, 32'h0, 1'b1, 1'b1, 0);
    run_instr(OP_BRANCH, F3_RSV3, 32'h500, 32'h8, 32'h0, 1'b0, 1'b0, 0);
    // Wrap-around of the target
    run_instr(OP_JAL, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b0, 0);
    check("jal_wrap", redirect_pc, 32'h10);

    // Reset while in FLUSH
    opcode = OP_BRANCH; funct3 = F3_BEQ; pc = 32'h300; imm = 32'h10; breq = 1'b1;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    check("pre_rst_valid", 32'(redirect_valid), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("pre_rst_flush", 32'(flush), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_outs", 32'({redirect_valid, flush, busy, misalign, illegal}), 32'd0);
    check("midrst_pc", redirect_pc, 32'd0);
    check("midrst_cnts", branch_cnt | taken_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_branch = 0; exp_taken = 0;
    tick();
    check("post_rst_idle", 32'({busy, redirect_valid, flush}), 32'd0);

    // FLUSH_CYCLES=0 instance: handshake returns straight to IDLE
    opcode = OP_JAL; pc = 32'h40; imm = 32'h8;
    ex_valid_z = 1'b1;
    tick();
    ex_valid_z = 1'b0;
    check("z_valid", 32'(z_redirect_valid), 32'd1);
    check("z_pc", z_redirect_pc, 32'h48);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("z_idle", 32'({z_busy, z_flush, z_redirect_valid}), 32'd0);
    check("z_taken_cnt", z_taken_cnt, 32'd1);

    // Randomized instructions against the reference rules
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 4))
        0, 1:    op = OP_BRANCH;
        2:       op = OP_JAL;
        3:       op = OP_JALR;
        default: op = ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
      endcase
      run_instr(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
    end

    check("z_never_flushed", 32'(z_flush_seen), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
